// File: rtl/lat_hist_collector.sv
// Latency histogram collector: bins a per-read latency stream into an
// on-chip counter RAM and keeps running count/min/max/sum statistics.
//
// Ports:
//   clk, rst_n        engine clock, synchronous active-low reset
//   clear             pulse: restart the zeroing sweep and statistics
//   lat_timer_valid   sample strobe
//   lat_timer         sample latency in cycles
//   rd_req, rd_bin    host bin-read request and bin index
//   rd_valid, rd_data host read response pulse and bin count
//   busy              zeroing sweep in progress (samples are dropped)
//   sample_cnt        samples accepted since last clear
//   drop_cnt          samples dropped while busy
//   lat_min, lat_max  extreme accepted latencies
//   lat_sum           sum of accepted latencies
module lat_hist_collector #(
    parameter int NUM_BINS  = 256,
    parameter int BIN_SHIFT = 0,
    parameter int CNT_WIDTH = 32,
    localparam int BIN_W    = $clog2(NUM_BINS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 lat_timer_valid,
    input  logic [15:0]          lat_timer,
    input  logic                 rd_req,
    input  logic [BIN_W-1:0]     rd_bin,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 busy,
    output logic [31:0]          sample_cnt,
    output logic [31:0]          drop_cnt,
    output logic [15:0]          lat_min,
    output logic [15:0]          lat_max,
    output logic [47:0]          lat_sum
);

    localparam logic [31:0]      MAX_BIN32 = 32'(NUM_BINS - 1);
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(NUM_BINS - 1);

    typedef enum logic {
        SWEEP,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] addr_q, addr_d;
    logic             sweep_we;

    // ------------------------------------------------------------------
    // Sweep / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sweep_we = 1'b0;
        unique case (state_q)
            SWEEP: begin
                sweep_we = 1'b1;
                if (addr_q == LAST_BIN) begin
                    state_d = RUN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
            end
        endcase
        // clear restarts the sweep from bin 0 in either state
        if (clear) begin
            state_d = SWEEP;
            addr_d  = '0;
        end
    end

    logic run;
    logic accept;
    logic drop;

    assign run    = (state_q == RUN);
    assign busy   = ~run;
    assign accept = lat_timer_valid & run & ~clear;
    assign drop   = lat_timer_valid & ~run & ~clear;

    // ------------------------------------------------------------------
    // Update pipeline: S0 sample, S1 bin + RAM read, S2 increment/write
    // ------------------------------------------------------------------
    logic                 s0_v, s1_v, s2_v;
    logic [15:0]          s0_lat, s1_lat;
    logic [BIN_W-1:0]     s0_bin, s1_bin, s2_bin;
    logic [15:0]          s0_sh;
    logic [CNT_WIDTH-1:0] mem_q;
    logic [CNT_WIDTH-1:0] s2_wval;
    logic                 s2_we;

    assign s0_sh  = s0_lat >> BIN_SHIFT;
    // Out-of-range latencies pile into the last bin
    assign s0_bin = ({16'd0, s0_sh} > MAX_BIN32) ? LAST_BIN
                                                 : BIN_W'(s0_sh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            // clear flushes everything in flight
            s0_v <= accept;
            s1_v <= s0_v & ~clear;
            s2_v <= s1_v & ~clear;
        end
    end

    always_ff @(posedge clk) begin
        s0_lat <= lat_timer;
        s1_lat <= s0_lat;
        s1_bin <= s0_bin;
        s2_bin <= s1_bin;
    end

    assign s2_wval = (&mem_q) ? mem_q : mem_q + 1'b1;
    assign s2_we   = s2_v & ~clear;

    // ------------------------------------------------------------------
    // Host read request tracking
    // ------------------------------------------------------------------
    logic             pend_q;
    logic [BIN_W-1:0] pend_bin;
    logic             hr_issue;
    logic             hr1_v, hr2_v;
    logic [CNT_WIDTH-1:0] hr2_data;

    // Host reads borrow the RAM read port only when S1 is idle
    assign hr_issue = pend_q & run & ~s1_v & ~clear;

    // ------------------------------------------------------------------
    // Counter RAM: one write port, one registered read-first read port
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] mem [NUM_BINS];
    logic                 we;
    logic [BIN_W-1:0]     waddr;
    logic [CNT_WIDTH-1:0] wdata;
    logic [BIN_W-1:0]     raddr;
    logic                 fwd;

    assign we    = sweep_we | s2_we;
    assign waddr = sweep_we ? addr_q : s2_bin;
    assign wdata = sweep_we ? '0 : s2_wval;
    assign raddr = s1_v ? s1_bin : pend_bin;
    // Read-first RAM returns stale data when S2 writes the same bin
    // on the same edge, so substitute the value being written.
    assign fwd   = s2_we & (s2_bin == raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        mem_q <= fwd ? s2_wval : mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            pend_bin <= '0;
            hr1_v    <= 1'b0;
            hr2_v    <= 1'b0;
            hr2_data <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (rd_req && !pend_q) begin
                pend_q   <= 1'b1;
                pend_bin <= rd_bin;
            end else if (hr_issue) begin
                pend_q <= 1'b0;
            end
            hr1_v <= hr_issue;
            hr2_v <= hr1_v;
            if (hr1_v) begin
                hr2_data <= mem_q;
            end
            rd_valid <= hr2_v;
            if (hr2_v) begin
                rd_data <= hr2_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Running statistics, fed from the registered sample copy in S1
    // ------------------------------------------------------------------
    logic [48:0] sum_ext;

    assign sum_ext = {1'b0, lat_sum} + {33'd0, s1_lat};

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sample_cnt <= '0;
            drop_cnt   <= '0;
            lat_min    <= 16'hFFFF;
            lat_max    <= '0;
            lat_sum    <= '0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
            if (s1_v) begin
                if (sample_cnt != '1) begin
                    sample_cnt <= sample_cnt + 32'd1;
                end
                if (s1_lat < lat_min) begin
                    lat_min <= s1_lat;
                end
                if (s1_lat > lat_max) begin
                    lat_max <= s1_lat;
                end
                lat_sum <= sum_ext[48] ? '1 : sum_ext[47:0];
            end
        end
    end

endmodule

// File: tb/tb_lat_hist_collector.sv
// Scoreboard bench for lat_hist_collector (BIN_SHIFT=2, CNT_WIDTH=10).
// Host-read expectations are queued at request time and checked on rd_valid.
module tb_lat_hist_collector;

    localparam int NB = 256;
    localparam int BS = 2;
    localparam int CW = 10;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          lat_timer_valid = 1'b0;
    logic [15:0]   lat_timer = '0;
    logic          rd_req = 1'b0;
    logic [BW-1:0] rd_bin = '0;
    logic          rd_valid;
    logic [CW-1:0] rd_data;
    logic          busy;
    logic [31:0]   sample_cnt;
    logic [31:0]   drop_cnt;
    logic [15:0]   lat_min;
    logic [15:0]   lat_max;
    logic [47:0]   lat_sum;

    lat_hist_collector #(
        .NUM_BINS (NB),
        .BIN_SHIFT(BS),
        .CNT_WIDTH(CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .lat_timer_valid(lat_timer_valid),
        .lat_timer      (lat_timer),
        .rd_req         (rd_req),
        .rd_bin         (rd_bin),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .busy           (busy),
        .sample_cnt     (sample_cnt),
        .drop_cnt       (drop_cnt),
        .lat_min        (lat_min),
        .lat_max        (lat_max),
        .lat_sum        (lat_sum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CW-1:0] sb[$];
    logic [CW-1:0] mon_exp;
    int n_cmp = 0;
    int n_err = 0;
    int rv_cyc = 0;

    // Monitor: pops one expectation per response pulse
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            rv_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected got=%0d want=none", rd_data);
            end else begin
                mon_exp = sb.pop_front();
                if (rd_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL rd_data got=%0d want=%0d", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_timeout got=%0d_pending want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic host_read(input int bin, input int exp, input bit lat);
        int req_edge;
        sb.push_back(CW'(exp));
        rd_req = 1'b1;
        rd_bin = BW'(bin);
        tick();
        req_edge = cyc;
        rd_req = 1'b0;
        wait_rsp();
        if (lat) chk("rd_latency", 64'(rv_cyc - req_edge), 3);
    endtask

    task automatic send_samples(input logic [15:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            lat_timer_valid = 1'b1;
            lat_timer = l;
            tick();
        end
        lat_timer_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Counts busy cycles; drives ndrop samples and optionally one
    // held read of bin 10 (expected 0 after the sweep).
    task automatic wait_sweep(input int ndrop, input int rd_at,
                              output int n);
        n = 0;
        while (busy && n < 1000) begin
            lat_timer_valid = (n < ndrop);
            lat_timer = 16'd8;
            rd_req = (n == rd_at);
            rd_bin = 8'd10;
            if (n == rd_at) sb.push_back('0);
            tick();
            n++;
        end
        lat_timer_valid = 1'b0;
        rd_req = 1'b0;
    endtask

    int nb;
    int last_edge;
    logic [15:0] basic_lat [4];

    initial begin
        basic_lat[0] = 16'd5;
        basic_lat[1] = 16'd6;
        basic_lat[2] = 16'd7;
        basic_lat[3] = 16'd300;

        // Reset values
        idle(3);
        chk("rst_busy", busy, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_lat_min", lat_min, 16'hFFFF);
        chk("rst_lat_max", lat_max, 0);
        chk("rst_lat_sum", lat_sum, 0);
        rst_n = 1'b1;
        wait_sweep(0, -1, nb);
        chk("reset_busy_cycles", nb, 256);

        // Every bin reads zero after the sweep
        for (int b = 0; b < NB; b++) host_read(b, 0, b == 0);
        chk("sweep_lat_min", lat_min, 16'hFFFF);

        // Basic binning
        for (int i = 0; i < 4; i++) begin
            lat_timer_valid = 1'b1;
            lat_timer = basic_lat[i];
            tick();
        end
        lat_timer_valid = 1'b0;
        idle(4);
        chk("basic_cnt", sample_cnt, 4);
        chk("basic_min", lat_min, 5);
        chk("basic_max", lat_max, 300);
        chk("basic_sum", lat_sum, 318);
        host_read(1, 3, 1'b0);
        host_read(63, 0, 1'b0);
        host_read(75, 1, 1'b0);

        // Statistics latency: visible after edge t+2, not t+1
        lat_timer_valid = 1'b1;
        lat_timer = 16'd2;
        tick();
        lat_timer_valid = 1'b0;
        tick();
        chk("stat_t1_cnt", sample_cnt, 4);
        tick();
        chk("stat_t2_cnt", sample_cnt, 5);
        chk("stat_t2_min", lat_min, 2);

        // Bin latency: read requested on the next edge sees the update
        lat_timer_valid = 1'b1;
        lat_timer = 16'd400;
        tick();
        lat_timer_valid = 1'b0;
        host_read(100, 1, 1'b0);

        // Hazard: 1000 back-to-back samples into bin 10
        send_samples(16'd40, 1000);
        idle(4);
        host_read(9, 0, 1'b0);
        host_read(10, 1000, 1'b0);
        host_read(11, 0, 1'b0);

        // Saturation of a 10-bit bin and out-of-range latency
        send_samples(16'd12, 1030);
        send_samples(16'hFFFF, 1);
        idle(4);
        host_read(3, 1023, 1'b0);
        host_read(255, 1, 1'b0);
        chk("sat_max", lat_max, 16'hFFFF);
        chk("sat_cnt", sample_cnt, 2037);

        // Clear: drops during busy, read held until RUN
        do_clear();
        wait_sweep(7, 3, nb);
        chk("clear_busy_cycles", nb, 256);
        wait_rsp();
        chk("clear_drop_cnt", drop_cnt, 7);
        chk("clear_sample_cnt", sample_cnt, 0);
        chk("clear_lat_sum", lat_sum, 0);

        // Read contention against a 50-sample stream
        fork
            begin
                send_samples(16'd41, 50);
                last_edge = cyc;
            end
            begin
                idle(5);
                sb.push_back(CW'(50));
                rd_req = 1'b1;
                rd_bin = 8'd10;
                tick();
                rd_req = 1'b0;
            end
        join
        wait_rsp();
        chk("contend_rv_edge", 64'(rv_cyc - last_edge), 5);
        chk("contend_cnt", sample_cnt, 50);
        chk("contend_sum", lat_sum, 2050);
        chk("contend_drop", drop_cnt, 7);
        host_read(11, 0, 1'b0);

        // Clear mid-run with samples in flight, then during the sweep
        send_samples(16'd8, 6);
        lat_timer_valid = 1'b1;
        lat_timer = 16'd8;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        lat_timer_valid = 1'b0;
        idle(20);
        send_samples(16'd8, 3);
        do_clear();
        wait_sweep(5, -1, nb);
        chk("restart_busy_cycles", nb, 256);
        chk("restart_drop", drop_cnt, 5);
        chk("restart_cnt", sample_cnt, 0);
        chk("restart_min", lat_min, 16'hFFFF);
        chk("restart_max", lat_max, 0);
        host_read(2, 0, 1'b0);
        host_read(10, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
